sdram_rd_fifo: RTL and testbench

Read-side buffer and prefetch controller placed directly downstream of the SDRAM read command stage. Issues burst read requests (`rd_en`, `rd_addr`, `rd_bst_len`) to that stage whenever there is room, and captures the returned words on `rd_ack`/`rd_sdram_data` into an on-chip FIFO. The FIFO is drained by the user read port. The SDRAM read address walks a circular window `[rd_addr_min, rd_addr_max]`.

---
 rtl/sdram_rd_fifo.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_sdram_rd_fifo.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_rd_fifo.sv
// sdram_rd_fifo
//   Read-side prefetch controller and word FIFO that sits directly
//   downstream of the SDRAM read command stage.
//   - The FSM issues burst requests (rd_en/rd_addr/rd_bst_len) whenever the
//     FIFO has room for a whole burst. The read address walks the circular
//     window [rd_addr_min, rd_addr_max].
//   - Words returned on rd_ack are captured into a circular buffer that the
//     user port drains with 1-cycle read latency.
//   - A flush that arrives mid-burst is deferred. The burst runs to rd_end,
//     its remaining words are dropped, and the clear happens in UPD.
//   Optional feature: define SDRAM_RD_FIFO_STAT_EN to add the stat_underflow
//   and stat_burst_cnt outputs.
module sdram_rd_fifo #(
    parameter int FIFO_DEPTH = 1024,
    parameter int LVL_W      = 11
) (
    input  logic             rfifo_clk,
    input  logic             rfifo_rst_n,
    input  logic             init_end,
    input  logic             rd_valid,
    input  logic             rd_flush,
    input  logic [23:0]      rd_addr_min,
    input  logic [23:0]      rd_addr_max,
    input  logic [9:0]       cfg_bst_len,
    input  logic             rd_ack,
    input  logic [15:0]      rd_sdram_data,
    input  logic             rd_end,
    output logic             rd_en,
    output logic [23:0]      rd_addr,
    output logic [9:0]       rd_bst_len,
    input  logic             user_rd_req,
    output logic [15:0]      user_rd_data,
    output logic             user_rd_vld,
    output logic [LVL_W-1:0] fifo_level,
    output logic             fifo_empty
`ifdef SDRAM_RD_FIFO_STAT_EN
    ,
    output logic             stat_underflow,
    output logic [15:0]      stat_burst_cnt
`endif
);

    // Buffer index width: the pointers carry one extra wrap bit.
    localparam int IDX_W = LVL_W - 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        BUSY,
        UPD
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e             state_q,        state_d;
    logic               rd_en_q,        rd_en_d;
    logic [23:0]        rd_addr_q,      rd_addr_d;
    logic [9:0]         rd_bst_len_q,   rd_bst_len_d;
    logic [23:0]        addr_ptr_q,     addr_ptr_d;
    logic               ptr_vld_q,      ptr_vld_d;
    logic               flush_pend_q,   flush_pend_d;

    logic [LVL_W-1:0]   wr_ptr_q,       wr_ptr_d;
    logic [LVL_W-1:0]   rd_ptr_q,       rd_ptr_d;
    logic [15:0]        user_rd_data_q, user_rd_data_d;
    logic               user_rd_vld_q,  user_rd_vld_d;

    logic [15:0]        mem_q [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    logic [LVL_W-1:0]   level;
    logic               empty;
    logic [31:0]        room;
    logic               start_ok;
    logic               in_burst;
    logic               wr_fire;
    logic               rd_fire;
    logic               do_clear;
    logic               upd_adv;
    logic [24:0]        next_sum;
    logic [25:0]        last_sum;
    logic               wrap;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   rd_idx;

    assign level = wr_ptr_q - rd_ptr_q;
    assign empty = (level == '0);
    assign room  = 32'(FIFO_DEPTH) - 32'(level);

    // Room is checked only in IDLE. Nothing is in flight there, so the
    // level already counts every word that can arrive.
    assign start_ok = init_end && rd_valid && !rd_flush
                   && (cfg_bst_len != '0)
                   && (room >= 32'(cfg_bst_len));

    assign in_burst = (state_q == REQ) || (state_q == BUSY);

    // While a flush is pending, or arriving, returned words are dropped and
    // pops are held off. The whole buffer is cleared shortly afterwards.
    assign wr_fire = in_burst && rd_ack && !flush_pend_q && !rd_flush;
    assign rd_fire = user_rd_req && !empty && !flush_pend_q && !rd_flush;

    assign wr_idx = wr_ptr_q[IDX_W-1:0];
    assign rd_idx = rd_ptr_q[IDX_W-1:0];

    // Next burst start, plus the last word that burst would touch. The carry
    // bits catch a start address that runs past the 24-bit space.
    assign next_sum = {1'b0, rd_addr_q} + {15'b0, rd_bst_len_q};
    assign last_sum = {1'b0, next_sum} + {16'b0, rd_bst_len_q} - 26'd1;
    assign wrap     = next_sum[24] || (last_sum > {2'b0, rd_addr_max});

    // ------------------------------------------------------------------
    // FSM next-state and request outputs
    // ------------------------------------------------------------------
    // NOTE: every signal gets its hold value first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        rd_en_d      = rd_en_q;
        rd_addr_d    = rd_addr_q;
        rd_bst_len_d = rd_bst_len_q;
        addr_ptr_d   = addr_ptr_q;
        ptr_vld_d    = ptr_vld_q;
        flush_pend_d = flush_pend_q;
        do_clear     = 1'b0;
        upd_adv      = 1'b0;

        case (state_q)
            IDLE: begin
                if (rd_flush) begin
                    do_clear  = 1'b1;
                    ptr_vld_d = 1'b0;
                end else if (start_ok) begin
                    state_d      = REQ;
                    rd_en_d      = 1'b1;
                    rd_addr_d    = ptr_vld_q ? addr_ptr_q : rd_addr_min;
                    rd_bst_len_d = cfg_bst_len;
                end
            end

            REQ: begin
                if (rd_flush) begin
                    flush_pend_d = 1'b1;
                end
                if (rd_ack) begin
                    rd_en_d = 1'b0;
                    // A one-word burst can complete with its first ack.
                    state_d = rd_end ? UPD : BUSY;
                end
            end

            BUSY: begin
                if (rd_flush) begin
                    flush_pend_d = 1'b1;
                end
                if (rd_end) begin
                    state_d = UPD;
                end
            end

            UPD: begin
                state_d = IDLE;
                if (flush_pend_q || rd_flush) begin
                    do_clear     = 1'b1;
                    ptr_vld_d    = 1'b0;
                    flush_pend_d = 1'b0;
                end else begin
                    addr_ptr_d = wrap ? rd_addr_min : next_sum[23:0];
                    ptr_vld_d  = 1'b1;
                    upd_adv    = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and request register bank.
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples values from before the edge, whatever the order of statements.
    always_ff @(posedge rfifo_clk or negedge rfifo_rst_n) begin
        if (!rfifo_rst_n) begin
            state_q      <= IDLE;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            rd_bst_len_q <= '0;
            addr_ptr_q   <= '0;
            ptr_vld_q    <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            rd_bst_len_q <= rd_bst_len_d;
            addr_ptr_q   <= addr_ptr_d;
            ptr_vld_q    <= ptr_vld_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers and user read port
    // ------------------------------------------------------------------
    // Pointer update and registered pop. A clear overrides any push or pop.
    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        user_rd_data_d = user_rd_data_q;
        user_rd_vld_d  = 1'b0;

        if (do_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_d = wr_ptr_q + LVL_W'(1);
            end
            if (rd_fire) begin
                rd_ptr_d       = rd_ptr_q + LVL_W'(1);
                user_rd_data_d = mem_q[rd_idx];
                user_rd_vld_d  = 1'b1;
            end
        end
    end

    // FIFO pointer and read-data registers.
    always_ff @(posedge rfifo_clk or negedge rfifo_rst_n) begin
        if (!rfifo_rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            user_rd_data_q <= '0;
            user_rd_vld_q  <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            user_rd_data_q <= user_rd_data_d;
            user_rd_vld_q  <= user_rd_vld_d;
        end
    end

    // Word storage.
    // NOTE: the storage array has no reset. The pointers decide which words
    // are valid, and leaving the array unreset lets it map onto block RAM.
    always_ff @(posedge rfifo_clk) begin
        if (wr_fire) begin
            mem_q[wr_idx] <= rd_sdram_data;
        end
    end

    // ------------------------------------------------------------------
    // Optional statistics
    // ------------------------------------------------------------------
`ifdef SDRAM_RD_FIFO_STAT_EN
    logic        stat_underflow_q, stat_underflow_d;
    logic [15:0] stat_burst_cnt_q, stat_burst_cnt_d;

    // Sticky underflow flag and count of completed bursts. A flush clears both.
    always_comb begin
        stat_underflow_d = stat_underflow_q;
        stat_burst_cnt_d = stat_burst_cnt_q;
        if (do_clear) begin
            stat_underflow_d = 1'b0;
            stat_burst_cnt_d = '0;
        end else begin
            if (user_rd_req && empty) begin
                stat_underflow_d = 1'b1;
            end
            if (upd_adv) begin
                stat_burst_cnt_d = stat_burst_cnt_q + 16'd1;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge rfifo_clk or negedge rfifo_rst_n) begin
        if (!rfifo_rst_n) begin
            stat_underflow_q <= 1'b0;
            stat_burst_cnt_q <= '0;
        end else begin
            stat_underflow_q <= stat_underflow_d;
            stat_burst_cnt_q <= stat_burst_cnt_d;
        end
    end

    assign stat_underflow = stat_underflow_q;
    assign stat_burst_cnt = stat_burst_cnt_q;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rd_en        = rd_en_q;
    assign rd_addr      = rd_addr_q;
    assign rd_bst_len   = rd_bst_len_q;
    assign user_rd_data = user_rd_data_q;
    assign user_rd_vld  = user_rd_vld_q;
    assign fifo_level   = level;
    assign fifo_empty   = empty;

endmodule

// File: tb/tb_sdram_rd_fifo.sv
// Testbench for sdram_rd_fifo (16-word FIFO).
// A behavioural read stage answers each rd_en with rd_bst_len acks followed
// by an rd_end pulse. Tests queue the expected burst requests and popped
// words. Two monitor processes compare those queues against the DUT
// whenever rd_en rises or user_rd_vld is high.
`timescale 1ns/1ps
module tb_sdram_rd_fifo;

    localparam int FIFO_DEPTH = 16;
    localparam int LVL_W      = 5;

    logic             rfifo_clk = 1'b0;
    logic             rfifo_rst_n;
    logic             init_end;
    logic             rd_valid;
    logic             rd_flush;
    logic [23:0]      rd_addr_min;
    logic [23:0]      rd_addr_max;
    logic [9:0]       cfg_bst_len;
    logic             rd_ack;
    logic [15:0]      rd_sdram_data;
    logic             rd_end;
    logic             rd_en;
    logic [23:0]      rd_addr;
    logic [9:0]       rd_bst_len;
    logic             user_rd_req;
    logic [15:0]      user_rd_data;
    logic             user_rd_vld;
    logic [LVL_W-1:0] fifo_level;
    logic             fifo_empty;
`ifdef SDRAM_RD_FIFO_STAT_EN
    logic             stat_underflow;
    logic [15:0]      stat_burst_cnt;
`endif

    sdram_rd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .LVL_W      (LVL_W)
    ) dut (
        .rfifo_clk      (rfifo_clk),
        .rfifo_rst_n    (rfifo_rst_n),
        .init_end       (init_end),
        .rd_valid       (rd_valid),
        .rd_flush       (rd_flush),
        .rd_addr_min    (rd_addr_min),
        .rd_addr_max    (rd_addr_max),
        .cfg_bst_len    (cfg_bst_len),
        .rd_ack         (rd_ack),
        .rd_sdram_data  (rd_sdram_data),
        .rd_end         (rd_end),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_bst_len     (rd_bst_len),
        .user_rd_req    (user_rd_req),
        .user_rd_data   (user_rd_data),
        .user_rd_vld    (user_rd_vld),
        .fifo_level     (fifo_level),
        .fifo_empty     (fifo_empty)
`ifdef SDRAM_RD_FIFO_STAT_EN
        ,
        .stat_underflow (stat_underflow),
        .stat_burst_cnt (stat_burst_cnt)
`endif
    );

    always #5 rfifo_clk = ~rfifo_clk;

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [23:0] addr;
        logic [9:0]  len;
    } req_t;

    req_t        exp_req[$];
    logic [15:0] exp_data[$];
    int          checks = 0;
    int          errors = 0;
    int          rises  = 0;
    logic        rd_en_seen = 1'b0;

    logic [15:0] data_seed;
    logic [15:0] m_seed_seen = 16'hFFFF;
    logic [15:0] m_ofs = '0;
    int          m_len;
    logic        m_abort;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    task automatic push_req(input logic [23:0] addr, input logic [9:0] len);
        req_t r;
        r.addr = addr;
        r.len  = len;
        exp_req.push_back(r);
    endtask

    task automatic push_data(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) exp_data.push_back(base + 16'(i));
    endtask

    // ------------------------------------------------------------------
    // Monitors
    // ------------------------------------------------------------------
    always @(negedge rfifo_clk) begin : req_monitor
        req_t r;
        if (rfifo_rst_n && rd_en && !rd_en_seen) begin
            rises++;
            if (exp_req.size() == 0) begin
                note_fail("unexpected rd_en");
            end else begin
                r = exp_req.pop_front();
                check("rd_addr", 32'(rd_addr), 32'(r.addr));
                check("rd_bst_len", 32'(rd_bst_len), 32'(r.len));
            end
        end
        rd_en_seen = rd_en;
    end

    always @(negedge rfifo_clk) begin : data_monitor
        logic [15:0] w;
        if (rfifo_rst_n && user_rd_vld) begin
            if (exp_data.size() == 0) begin
                note_fail("unexpected user_rd_vld");
            end else begin
                w = exp_data.pop_front();
                check("user_rd_data", 32'(user_rd_data), 32'(w));
            end
        end
    end

    // ------------------------------------------------------------------
    // Read-stage model: one cycle after it sees rd_en it returns rd_bst_len
    // consecutive words data_seed+n, then pulses rd_end. Reset aborts it.
    // ------------------------------------------------------------------
    initial begin : read_stage
        rd_ack        = 1'b0;
        rd_end        = 1'b0;
        rd_sdram_data = '0;
        forever begin
            @(negedge rfifo_clk);
            if (rfifo_rst_n && rd_en) begin
                if (data_seed != m_seed_seen) begin
                    m_seed_seen = data_seed;
                    m_ofs       = '0;
                end
                m_len   = int'(rd_bst_len);
                m_abort = 1'b0;
                for (int i = 0; i < m_len; i++) begin
                    @(negedge rfifo_clk);
                    if (!rfifo_rst_n) begin
                        m_abort = 1'b1;
                        rd_ack  = 1'b0;
                        break;
                    end
                    rd_ack        = 1'b1;
                    rd_sdram_data = data_seed + m_ofs;
                    m_ofs         = m_ofs + 16'd1;
                end
                if (!m_abort) begin
                    @(negedge rfifo_clk);
                    rd_ack = 1'b0;
                    rd_end = 1'b1;
                    @(negedge rfifo_clk);
                    rd_end = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic wait_rd_en(input string tag);
        int n;
        n = 0;
        while (!rd_en && n < 200) begin
            @(negedge rfifo_clk);
            n++;
        end
        if (!rd_en) note_fail({tag, " timeout waiting for rd_en"});
    endtask

    task automatic wait_ack(input string tag);
        int n;
        n = 0;
        while (!rd_ack && n < 50) begin
            @(negedge rfifo_clk);
            n++;
        end
        if (!rd_ack) note_fail({tag, " timeout waiting for rd_ack"});
    endtask

    // Waits for the level, then lets the burst tail (rd_end, UPD) settle.
    task automatic wait_level(input int lvl, input string tag);
        int n;
        n = 0;
        while (fifo_level !== LVL_W'(lvl) && n < 300) begin
            @(negedge rfifo_clk);
            n++;
        end
        if (fifo_level !== LVL_W'(lvl)) note_fail({tag, " timeout waiting for fifo_level"});
        repeat (4) @(negedge rfifo_clk);
    endtask

    // Back-to-back pops from a FIFO known to hold at least n words.
    task automatic pop_n(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            user_rd_req = 1'b1;
            @(negedge rfifo_clk);
            check({tag, " pop latency vld"}, 32'(user_rd_vld), 32'd1);
        end
        user_rd_req = 1'b0;
        @(negedge rfifo_clk);
    endtask

    task automatic flush_pulse();
        rd_flush = 1'b1;
        @(negedge rfifo_clk);
        rd_flush = 1'b0;
        repeat (2) @(negedge rfifo_clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " rd_en"}, 32'(rd_en), 32'd0);
        check({tag, " rd_addr"}, 32'(rd_addr), 32'd0);
        check({tag, " rd_bst_len"}, 32'(rd_bst_len), 32'd0);
        check({tag, " user_rd_data"}, 32'(user_rd_data), 32'd0);
        check({tag, " user_rd_vld"}, 32'(user_rd_vld), 32'd0);
        check({tag, " fifo_level"}, 32'(fifo_level), 32'd0);
        check({tag, " fifo_empty"}, 32'(fifo_empty), 32'd1);
`ifdef SDRAM_RD_FIFO_STAT_EN
        check({tag, " stat_underflow"}, 32'(stat_underflow), 32'd0);
        check({tag, " stat_burst_cnt"}, 32'(stat_burst_cnt), 32'd0);
`endif
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin : stimulus
        int base;

        rfifo_rst_n = 1'b0;
        init_end    = 1'b0;
        rd_valid    = 1'b0;
        rd_flush    = 1'b0;
        rd_addr_min = 24'h000000;
        rd_addr_max = 24'h0003FF;
        cfg_bst_len = 10'd8;
        user_rd_req = 1'b0;
        data_seed   = 16'h1000;

        repeat (2) @(negedge rfifo_clk);
        check_reset_outputs("reset");
        rfifo_rst_n = 1'b1;
        @(negedge rfifo_clk);

        // ---- Single burst ------------------------------------------------
        push_req(24'h000000, 10'd8);
        init_end = 1'b1;
        rd_valid = 1'b1;
        wait_rd_en("single");
        rd_valid = 1'b0;
        wait_level(8, "single");
        check("single fifo_level", 32'(fifo_level), 32'd8);
        check("single fifo_empty", 32'(fifo_empty), 32'd0);
`ifdef SDRAM_RD_FIFO_STAT_EN
        check("single stat_burst_cnt", 32'(stat_burst_cnt), 32'd1);
`endif
        push_data(16'h1000, 8);
        pop_n(8, "single");
        check("single drained level", 32'(fifo_level), 32'd0);
        check("single drained empty", 32'(fifo_empty), 32'd1);
        check("single vld after pops", 32'(user_rd_vld), 32'd0);

        // ---- Back-pressure -----------------------------------------------
        flush_pulse();
        data_seed = 16'h2000;
        push_req(24'h000000, 10'd8);
        push_req(24'h000008, 10'd8);
        base     = rises;
        rd_valid = 1'b1;
        wait_level(16, "bp");
        repeat (20) @(negedge rfifo_clk);
        check("bp burst count", 32'(rises - base), 32'd2);
        check("bp rd_en held low", 32'(rd_en), 32'd0);
        check("bp full level", 32'(fifo_level), 32'd16);
        push_req(24'h000010, 10'd8);
        push_data(16'h2000, 8);
        pop_n(8, "bp");
        wait_level(16, "bp refill");
        rd_valid = 1'b0;
        check("bp burst count after pop", 32'(rises - base), 32'd3);
        push_data(16'h2008, 16);
        pop_n(16, "bp drain");
        check("bp drained level", 32'(fifo_level), 32'd0);

        // ---- Simultaneous push/pop and pop while empty --------------------
        flush_pulse();
        data_seed = 16'h3000;
        push_req(24'h000000, 10'd8);
        rd_valid = 1'b1;
        wait_rd_en("simul");
        rd_valid = 1'b0;
        wait_level(8, "simul");
        push_data(16'h3000, 3);
        pop_n(3, "simul");
        check("simul level before", 32'(fifo_level), 32'd5);
        push_req(24'h000008, 10'd8);
        push_data(16'h3003, 8);
        rd_valid = 1'b1;
        wait_rd_en("simul2");
        rd_valid = 1'b0;
        @(negedge rfifo_clk);
        user_rd_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge rfifo_clk);
            check("simul level steady", 32'(fifo_level), 32'd5);
        end
        user_rd_req = 1'b0;
        repeat (4) @(negedge rfifo_clk);
        push_data(16'h300B, 5);
        pop_n(5, "simul tail");
        check("simul empty", 32'(fifo_empty), 32'd1);
        user_rd_req = 1'b1;
        @(negedge rfifo_clk);
        user_rd_req = 1'b0;
        check("underflow vld", 32'(user_rd_vld), 32'd0);
`ifdef SDRAM_RD_FIFO_STAT_EN
        check("stat_underflow set", 32'(stat_underflow), 32'd1);
`endif
        @(negedge rfifo_clk);

        // ---- Wrap ----------------------------------------------------------
        rd_addr_min = 24'h000100;
        rd_addr_max = 24'h00011F;
        cfg_bst_len = 10'd16;
        flush_pulse();
`ifdef SDRAM_RD_FIFO_STAT_EN
        check("flush clears underflow", 32'(stat_underflow), 32'd0);
`endif
        data_seed = 16'h4000;
        push_req(24'h000100, 10'd16);
        push_req(24'h000110, 10'd16);
        push_req(24'h000100, 10'd16);
        push_req(24'h000110, 10'd16);
        push_data(16'h4000, 64);
        base        = rises;
        user_rd_req = 1'b1;
        rd_valid    = 1'b1;
        for (int n = 0; n < 600 && (rises - base) < 4; n++) @(negedge rfifo_clk);
        rd_valid = 1'b0;
        check("wrap burst count", 32'(rises - base), 32'd4);
        for (int n = 0; n < 100 && exp_data.size() != 0; n++) @(negedge rfifo_clk);
        user_rd_req = 1'b0;
        repeat (4) @(negedge rfifo_clk);
        check("wrap words left", 32'(exp_data.size()), 32'd0);
        check("wrap level", 32'(fifo_level), 32'd0);

        // ---- Flush mid-burst -----------------------------------------------
        rd_addr_min = 24'h000000;
        rd_addr_max = 24'h0003FF;
        cfg_bst_len = 10'd8;
        flush_pulse();
        data_seed = 16'h5000;
        push_req(24'h000000, 10'd8);
        rd_valid = 1'b1;
        wait_rd_en("flush");
        rd_valid = 1'b0;
        wait_ack("flush");
        @(negedge rfifo_clk);
        rd_flush = 1'b1;
        @(negedge rfifo_clk);
        rd_flush    = 1'b0;
        user_rd_req = 1'b1;
        @(negedge rfifo_clk);
        check("flush pending vld", 32'(user_rd_vld), 32'd0);
        repeat (12) @(negedge rfifo_clk);
        user_rd_req = 1'b0;
        @(negedge rfifo_clk);
        check("flush level", 32'(fifo_level), 32'd0);
        check("flush empty", 32'(fifo_empty), 32'd1);
        data_seed = 16'h5100;
        push_req(24'h000000, 10'd8);
        rd_valid = 1'b1;
        wait_rd_en("post flush");
        rd_valid = 1'b0;
        wait_level(8, "post flush");
        push_data(16'h5100, 8);
        pop_n(8, "post flush");

        // ---- Reset mid-burst -----------------------------------------------
        rd_addr_min = 24'h000040;
        flush_pulse();
        data_seed = 16'h6000;
        push_req(24'h000040, 10'd8);
        rd_valid = 1'b1;
        wait_rd_en("pre reset");
        rd_valid = 1'b0;
        wait_level(8, "pre reset");
        push_data(16'h6000, 8);
        pop_n(8, "pre reset");
        data_seed = 16'h6100;
        push_req(24'h000048, 10'd8);
        rd_valid = 1'b1;
        wait_rd_en("reset burst");
        rd_valid = 1'b0;
        wait_ack("reset burst");
        @(negedge rfifo_clk);
        rfifo_rst_n = 1'b0;
        #1;
        check_reset_outputs("mid-burst reset");
        repeat (3) @(negedge rfifo_clk);
        rfifo_rst_n = 1'b1;
        @(negedge rfifo_clk);
        data_seed = 16'h7000;
        push_req(24'h000040, 10'd8);
        rd_valid = 1'b1;
        wait_rd_en("after reset");
        rd_valid = 1'b0;
        wait_level(8, "after reset");
        push_data(16'h7000, 8);
        pop_n(8, "after reset");

        repeat (4) @(negedge rfifo_clk);
        check("pending requests", 32'(exp_req.size()), 32'd0);
        check("pending words", 32'(exp_data.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
